// File: rtl/sll_pkg.sv
// Shared op codes, FSM state encoding and the NULL-address helper
// for the singly linked list core.
package sll_pkg;

    typedef enum logic [1:0] {
        OP_READ         = 2'b00,
        OP_DELETE_VALUE = 2'b01,
        OP_PUSH_BACK    = 2'b10,
        OP_PUSH_FRONT   = 2'b11
    } sll_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StFind,
        StDone
    } sll_state_e;

    // All-ones address of the given width marks "no node".
    function automatic int unsigned null_addr(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sll_free_slot_finder.sv
// Priority encoder over the slot valid bits: lowest free index and an
// all-full flag. free_idx is all-ones when no slot is free.
module sll_free_slot_finder #(
    parameter int MAX_NODE   = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [MAX_NODE-1:0]   valid,
    output logic [ADDR_WIDTH-1:0] free_idx,
    output logic                  all_full
);

    always_comb begin
        free_idx = '1;
        all_full = &valid;
        // Descending scan so the lowest free slot is the last one written.
        for (int i = MAX_NODE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = ADDR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/singly_linked_list_core.sv
// Register-file singly linked list with read, delete-first-by-value,
// push-back and push-front behind a start/done command handshake.
module singly_linked_list_core
    import sll_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8,
    localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [1:0]            op,
    input  logic                  op_start,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  op_done,
    output logic [ADDR_WIDTH-1:0] next_node_addr,
    output logic [ADDR_WIDTH-1:0] head,
    output logic [ADDR_WIDTH-1:0] tail,
    output logic                  full,
    output logic                  empty,
    output logic                  fault
);

    localparam int IDX_WIDTH = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1;
    localparam logic [ADDR_WIDTH-1:0] NULL_ADDR = ADDR_WIDTH'(null_addr(ADDR_WIDTH));

    sll_state_e            state_q, state_d;
    sll_op_e               op_q, op_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q [MAX_NODE];
    logic [DATA_WIDTH-1:0] data_d [MAX_NODE];
    logic [ADDR_WIDTH-1:0] next_q [MAX_NODE];
    logic [ADDR_WIDTH-1:0] next_d [MAX_NODE];
    logic [MAX_NODE-1:0]   valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0] next_out_q, next_out_d;
    logic                  fault_q, fault_d;

    logic [ADDR_WIDTH-1:0] free_idx;
    logic                  all_full;

    function automatic logic [IDX_WIDTH-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_WIDTH-1:0];
    endfunction

    sll_free_slot_finder #(
        .MAX_NODE  (MAX_NODE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_free_slot_finder (
        .valid   (valid_q),
        .free_idx(free_idx),
        .all_full(all_full)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        key_d      = key_q;
        addr_d     = addr_q;
        data_d     = data_q;
        next_d     = next_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cur_d      = cur_q;
        prev_d     = prev_q;
        data_out_d = data_out_q;
        next_out_d = next_out_q;
        fault_d    = fault_q;

        unique case (state_q)
            StIdle: begin
                if (op_start) begin
                    state_d = StExec;
                    op_d    = sll_op_e'(op);
                    key_d   = data_in;
                    addr_d  = addr_in;
                end
            end
            StExec: begin
                state_d = StDone;
                unique case (op_q)
                    OP_READ: begin
                        if (addr_q >= ADDR_WIDTH'(MAX_NODE) || !valid_q[idx(addr_q)]) begin
                            fault_d    = 1'b1;
                            data_out_d = '0;
                            next_out_d = NULL_ADDR;
                        end else begin
                            fault_d    = 1'b0;
                            data_out_d = data_q[idx(addr_q)];
                            next_out_d = next_q[idx(addr_q)];
                        end
                    end
                    OP_DELETE_VALUE: begin
                        state_d = StFind;
                        cur_d   = head_q;
                        prev_d  = NULL_ADDR;
                    end
                    OP_PUSH_BACK: begin
                        if (all_full) begin
                            fault_d = 1'b1;
                        end else begin
                            fault_d                 = 1'b0;
                            data_d[idx(free_idx)]   = key_q;
                            next_d[idx(free_idx)]   = NULL_ADDR;
                            valid_d[idx(free_idx)]  = 1'b1;
                            if (head_q == NULL_ADDR) begin
                                head_d = free_idx;
                            end else begin
                                next_d[idx(tail_q)] = free_idx;
                            end
                            tail_d = free_idx;
                        end
                    end
                    OP_PUSH_FRONT: begin
                        if (all_full) begin
                            fault_d = 1'b1;
                        end else begin
                            fault_d                = 1'b0;
                            data_d[idx(free_idx)]  = key_q;
                            next_d[idx(free_idx)]  = head_q;
                            valid_d[idx(free_idx)] = 1'b1;
                            head_d                 = free_idx;
                            if (head_q == NULL_ADDR) begin
                                tail_d = free_idx;
                            end
                        end
                    end
                endcase
            end
            StFind: begin
                if (cur_q == NULL_ADDR) begin
                    state_d = StDone;
                    fault_d = 1'b1;
                end else if (data_q[idx(cur_q)] == key_q) begin
                    state_d             = StDone;
                    fault_d             = 1'b0;
                    valid_d[idx(cur_q)] = 1'b0;
                    if (cur_q == head_q) begin
                        head_d = next_q[idx(cur_q)];
                    end else begin
                        next_d[idx(prev_q)] = next_q[idx(cur_q)];
                    end
                    // prev is still NULL when the removed node was also head.
                    if (cur_q == tail_q) begin
                        tail_d = prev_q;
                    end
                end else begin
                    prev_d = cur_q;
                    cur_d  = next_q[idx(cur_q)];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OP_READ;
            key_q   <= '0;
            addr_q  <= '0;
            for (int i = 0; i < MAX_NODE; i++) begin
                data_q[i] <= '0;
                next_q[i] <= NULL_ADDR;
            end
            valid_q    <= '0;
            head_q     <= NULL_ADDR;
            tail_q     <= NULL_ADDR;
            cur_q      <= NULL_ADDR;
            prev_q     <= NULL_ADDR;
            data_out_q <= '0;
            next_out_q <= NULL_ADDR;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            key_q      <= key_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            next_q     <= next_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            data_out_q <= data_out_d;
            next_out_q <= next_out_d;
            fault_q    <= fault_d;
        end
    end

    assign op_done        = (state_q == StDone);
    assign data_out       = data_out_q;
    assign next_node_addr = next_out_q;
    assign fault          = fault_q;
    assign head           = head_q;
    assign tail           = tail_q;
    assign full           = all_full;
    assign empty          = (head_q == NULL_ADDR);

endmodule

// File: tb/tb_singly_linked_list_core.sv
// Randomized and directed bench for singly_linked_list_core; the reference
// keeps the list as an ordered queue of slot numbers.
module tb_singly_linked_list_core;

    localparam int NN = 8;
    localparam logic [3:0] NUL = 4'hF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] addr_in = '0;
    logic [1:0] op = '0;
    logic       op_start = 1'b0;
    logic [7:0] data_out;
    logic       op_done;
    logic [3:0] next_node_addr, head, tail;
    logic       full, empty, fault;

    singly_linked_list_core dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .addr_in       (addr_in),
        .op            (op),
        .op_start      (op_start),
        .data_out      (data_out),
        .op_done       (op_done),
        .next_node_addr(next_node_addr),
        .head          (head),
        .tail          (tail),
        .full          (full),
        .empty         (empty),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference: list order as a queue of slot numbers plus per-slot payload.
    int         ord[$];
    logic [7:0] m_data [NN];
    bit         m_used [NN];
    logic [7:0] m_dout;
    logic [3:0] m_nxt;
    logic       m_fault;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_head();
        return (ord.size() == 0) ? NUL : 4'(ord[0]);
    endfunction

    function automatic logic [3:0] m_tail();
        return (ord.size() == 0) ? NUL : 4'(ord[ord.size() - 1]);
    endfunction

    function automatic logic [3:0] m_next(input int slot);
        for (int i = 0; i < ord.size(); i++) begin
            if (ord[i] == slot) return (i + 1 < ord.size()) ? 4'(ord[i + 1]) : NUL;
        end
        return NUL;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NN; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        ord.delete();
        for (int i = 0; i < NN; i++) begin
            m_used[i] = 1'b0;
            m_data[i] = '0;
        end
        m_dout  = '0;
        m_nxt   = NUL;
        m_fault = 1'b0;
    endtask

    // Applies one op to the reference; returns accept-to-op_done latency.
    task automatic model_apply(input logic [1:0] o, input logic [7:0] d, input logic [3:0] a,
                               output int exp_lat);
        int found;
        int s;
        exp_lat = 2;
        case (o)
            2'b00: begin
                if (a >= NN || !m_used[a]) begin
                    m_fault = 1'b1;
                    m_dout  = '0;
                    m_nxt   = NUL;
                end else begin
                    m_fault = 1'b0;
                    m_dout  = m_data[a];
                    m_nxt   = m_next(int'(a));
                end
            end
            2'b01: begin
                found = -1;
                for (int i = 0; i < ord.size(); i++) begin
                    if (found < 0 && m_data[ord[i]] == d) found = i;
                end
                if (found < 0) begin
                    m_fault = 1'b1;
                    exp_lat = ord.size() + 3;
                end else begin
                    m_fault = 1'b0;
                    exp_lat = found + 3;
                    m_used[ord[found]] = 1'b0;
                    ord.delete(found);
                end
            end
            default: begin
                if (ord.size() == NN) begin
                    m_fault = 1'b1;
                end else begin
                    m_fault   = 1'b0;
                    s         = m_free();
                    m_data[s] = d;
                    m_used[s] = 1'b1;
                    if (o == 2'b10) ord.push_back(s);
                    else ord.push_front(s);
                end
            end
        endcase
    endtask

    task automatic check_outputs(input bit is_read);
        check_val("fault", fault, m_fault);
        if (is_read) begin
            check_val("data_out", data_out, m_dout);
            check_val("next_node_addr", next_node_addr, m_nxt);
        end
        check_val("head", head, m_head());
        check_val("tail", tail, m_tail());
        check_val("full", full, ord.size() == NN);
        check_val("empty", empty, ord.size() == 0);
    endtask

    task automatic check_reset_state();
        check_val("rst_head", head, NUL);
        check_val("rst_tail", tail, NUL);
        check_val("rst_empty", empty, 1);
        check_val("rst_full", full, 0);
        check_val("rst_op_done", op_done, 0);
        check_val("rst_fault", fault, 0);
        check_val("rst_data_out", data_out, 0);
        check_val("rst_next", next_node_addr, NUL);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        op_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check_reset_state();
    endtask

    task automatic do_op(input logic [1:0] o, input logic [7:0] d, input logic [3:0] a);
        int exp_lat;
        int lat;
        model_apply(o, d, a, exp_lat);
        op       = o;
        data_in  = d;
        addr_in  = a;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        lat = 1;
        while (!op_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", lat, exp_lat);
        check_outputs(o == 2'b00);
        @(posedge clk);
        #1;
        check_val("done_pulse", op_done, 0);
    endtask

    initial begin
        int n;
        int dummy;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();

        // op_start held with Push_back 12: eight fills, then faults.
        op = 2'b10;
        data_in = 8'd12;
        op_start = 1'b1;
        n = 0;
        for (int c = 0; c < 86; c++) begin
            if (c == 80) op_start = 1'b0;
            @(posedge clk);
            #1;
            if (op_done) begin
                n++;
                model_apply(2'b10, 8'd12, 4'd0, dummy);
                check_outputs(1'b0);
                if (n == 8) check_val("hold_full", full, 1);
                if (n > 8) check_val("hold_fault", fault, 1);
            end
        end
        check_val("hold_ops", n, 27);
        for (int i = 0; i < NN; i++) do_op(2'b00, 8'd0, 4'(i));

        // Push_back 5, Push_front 9, read head node.
        do_reset();
        do_op(2'b10, 8'd5, 4'd0);
        do_op(2'b11, 8'd9, 4'd0);
        check_val("pf_head", head, 1);
        check_val("pf_tail", tail, 0);
        do_op(2'b00, 8'd0, 4'd1);
        check_val("pf_read", data_out, 9);
        check_val("pf_read_next", next_node_addr, 0);

        // Delete from the middle, then slot reuse.
        do_reset();
        do_op(2'b10, 8'd5, 4'd0);
        do_op(2'b10, 8'd7, 4'd0);
        do_op(2'b10, 8'd9, 4'd0);
        do_op(2'b01, 8'd7, 4'd0);
        do_op(2'b00, 8'd0, 4'd0);
        check_val("del_relink", next_node_addr, 2);
        do_op(2'b00, 8'd0, 4'd1);
        check_val("del_freed", fault, 1);
        do_op(2'b10, 8'd3, 4'd0);
        check_val("reuse_tail", tail, 1);
        do_op(2'b01, 8'd42, 4'd0);
        check_val("miss_fault", fault, 1);

        // Sole node delete, out-of-range read.
        do_reset();
        do_op(2'b10, 8'd1, 4'd0);
        do_op(2'b01, 8'd1, 4'd0);
        check_val("sole_empty", empty, 1);
        do_op(2'b00, 8'd0, 4'd8);
        check_val("oor_data", data_out, 0);

        // Reset in the middle of a delete walk.
        do_reset();
        for (int i = 0; i < NN; i++) do_op(2'b10, 8'(i), 4'd0);
        op = 2'b01;
        data_in = 8'd7;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Randomized traffic against the queue model.
        for (int t = 0; t < 400; t++) begin
            logic [1:0] ro;
            ro = 2'($urandom_range(0, 3));
            do_op(ro, 8'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
